// File: rtl/att_lookup_scheduler_if.sv
// Bundles the setup-write, ATT and requester signals of att_lookup_scheduler.
// Optional ATT_LOOKUP_STATS_EN adds the lookup/stall counter outputs.
interface att_lookup_scheduler_if #(
    parameter int NUM_REQ                    = 4,
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11
);
    localparam int LA = LITERAL_ADDRESS_WIDTH;
    localparam int CW = CLAUSE_TABLE_ADDRESS_WIDTH;
    localparam int CC = CLAUSE_COUNT;

    logic                       load_start_i;
    logic                       load_done_i;
    logic                       axi_wr_en_i;
    logic [LA:0]                axi_wr_addr_i;
    logic [CW+CC-1:0]           axi_wr_data_i;
    logic                       att_wr_en_o;
    logic [LA:0]                att_wr_addr_o;
    logic [CW+CC-1:0]           att_wr_data_o;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ*(LA-1)-1:0]  req_addr_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [LA-2:0]              att_rd_addr_o;
    logic [CW-1:0]              att_addr_i;
    logic [CC-1:0]              att_mask_i;
    logic [NUM_REQ-1:0]         rsp_valid_o;
    logic [CW-1:0]              rsp_addr_o;
    logic [CC-1:0]              rsp_mask_o;
    logic [1:0]                 mode_o;
    logic                       wr_reject_o;
`ifdef ATT_LOOKUP_STATS_EN
    logic [31:0]                lookup_cnt_o;
    logic [31:0]                stall_cnt_o;
`endif

    modport master (
        output load_start_i, load_done_i, axi_wr_en_i, axi_wr_addr_i, axi_wr_data_i,
        output req_valid_i, req_addr_i, att_addr_i, att_mask_i,
        input  att_wr_en_o, att_wr_addr_o, att_wr_data_o, req_ready_o, att_rd_addr_o,
        input  rsp_valid_o, rsp_addr_o, rsp_mask_o, mode_o, wr_reject_o
`ifdef ATT_LOOKUP_STATS_EN
        , input lookup_cnt_o, stall_cnt_o
`endif
    );

    modport slave (
        input  load_start_i, load_done_i, axi_wr_en_i, axi_wr_addr_i, axi_wr_data_i,
        input  req_valid_i, req_addr_i, att_addr_i, att_mask_i,
        output att_wr_en_o, att_wr_addr_o, att_wr_data_o, req_ready_o, att_rd_addr_o,
        output rsp_valid_o, rsp_addr_o, rsp_mask_o, mode_o, wr_reject_o
`ifdef ATT_LOOKUP_STATS_EN
        , output lookup_cnt_o, stall_cnt_o
`endif
    );
endinterface

// File: rtl/att_lookup_scheduler.sv
// ATT controller: gates setup writes to LOAD mode, round-robin shares the ATT read port in RUN.
// Define ATT_LOOKUP_STATS_EN to add saturating lookup/stall counters.
module att_lookup_scheduler #(
    parameter int NUM_REQ                    = 4,
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    att_lookup_scheduler_if.slave bus
);
    localparam int LA   = LITERAL_ADDRESS_WIDTH;
    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               grant_en_s;
    logic               load_mode_s;
    logic               load_entry_s;
    logic [IDXW-1:0]    ptr_r;
    logic [IDXW-1:0]    cand_s;
    logic [IDXW-1:0]    gnt_idx_s;
    logic               gnt_any_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [LA-2:0]      rd_addr_s;
    logic [NUM_REQ-1:0] inflight_r;
    logic               wr_reject_r;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (bus.load_start_i) state_nxt_s = LOAD;  else state_nxt_s = IDLE;
            LOAD:    if (bus.load_done_i)  state_nxt_s = RUN;   else state_nxt_s = LOAD;
            RUN:     if (bus.load_start_i) state_nxt_s = DRAIN; else state_nxt_s = RUN;
            DRAIN:   state_nxt_s = LOAD;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; a load request in RUN suppresses that cycle's grant
    always_comb begin
        grant_en_s  = 1'b0;
        load_mode_s = 1'b0;
        case (state_r)
            LOAD:    load_mode_s = 1'b1;
            RUN:     grant_en_s  = ~bus.load_start_i;
            default: begin
                grant_en_s  = 1'b0;
                load_mode_s = 1'b0;
            end
        endcase
    end

    assign load_entry_s = (state_nxt_s == LOAD) && (state_r != LOAD);

    // Round-robin search starting one above the last granted index
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = ptr_r;
        cand_s    = ptr_r;
        gnt_s     = '0;
        if (grant_en_s) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand_s = IDXW'((int'(ptr_r) + i) % NUM_REQ);
                if (!gnt_any_s && bus.req_valid_i[cand_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = cand_s;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        if (gnt_any_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Read-address mux for the granted requester, zero when idle
    always_comb begin
        rd_addr_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_s[k]) begin
                rd_addr_s = bus.req_addr_i[k*(LA-1) +: (LA-1)];
            end else begin
                rd_addr_s = rd_addr_s;
            end
        end
    end

    // Pointer, in-flight grant and sticky write-reject flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r       <= IDXW'(NUM_REQ - 1);
            inflight_r  <= '0;
            wr_reject_r <= 1'b0;
        end else begin
            inflight_r <= gnt_s;
            if (gnt_any_s) begin
                ptr_r <= gnt_idx_s;
            end
            if (bus.axi_wr_en_i && !load_mode_s) begin
                wr_reject_r <= 1'b1;
            end else if (load_entry_s) begin
                wr_reject_r <= 1'b0;
            end
        end
    end

    assign bus.att_wr_en_o   = bus.axi_wr_en_i & load_mode_s;
    assign bus.att_wr_addr_o = bus.axi_wr_addr_i;
    assign bus.att_wr_data_o = bus.axi_wr_data_i;
    assign bus.req_ready_o   = gnt_s;
    assign bus.att_rd_addr_o = rd_addr_s;
    assign bus.rsp_valid_o   = inflight_r;
    assign bus.rsp_addr_o    = bus.att_addr_i;
    assign bus.rsp_mask_o    = bus.att_mask_i;
    assign bus.mode_o        = state_r;
    assign bus.wr_reject_o   = wr_reject_r;

`ifdef ATT_LOOKUP_STATS_EN
    logic [31:0] lookup_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        stall_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

    assign stall_s = (state_r == RUN) && (|(bus.req_valid_i & ~gnt_s));

    // Statistics counters, restarted at every table load
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lookup_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else if (load_entry_s) begin
            lookup_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else begin
            if (gnt_any_s) lookup_cnt_r <= sat_inc(lookup_cnt_r);
            if (stall_s)   stall_cnt_r  <= sat_inc(stall_cnt_r);
        end
    end

    assign bus.lookup_cnt_o = lookup_cnt_r;
    assign bus.stall_cnt_o  = stall_cnt_r;
`endif
endmodule

// File: tb/tb_att_lookup_scheduler.sv
// Self-checking bench for att_lookup_scheduler: directed vector table, reset corner, random run vs model.
module tb_att_lookup_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    att_lookup_scheduler_if #(.NUM_REQ(4), .CLAUSE_COUNT(20), .LITERAL_ADDRESS_WIDTH(12),
                              .CLAUSE_TABLE_ADDRESS_WIDTH(11)) bus ();

    att_lookup_scheduler #(.NUM_REQ(4), .CLAUSE_COUNT(20), .LITERAL_ADDRESS_WIDTH(12),
                           .CLAUSE_TABLE_ADDRESS_WIDTH(11)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // ATT stand-in: fixed contents, registered read port
    logic [10:0] mem_a [0:2047];
    logic [19:0] mem_m [0:2047];
    always @(posedge clk) begin
        bus.att_addr_i <= mem_a[bus.att_rd_addr_o];
        bus.att_mask_i <= mem_m[bus.att_rd_addr_o];
    end

    // Reference model state: mode, last granted index, outstanding response, reject flag
    int          m_mode;
    int          m_ptr;
    bit          m_pv;
    int          m_pi;
    logic [10:0] m_pa;
    bit          m_rej;

    typedef struct {
        logic        ls, ld, we;
        logic [12:0] wa;
        logic [3:0]  rv;
        logic [1:0]  e_mode;
        logic        e_wen;
        logic [3:0]  e_rdy, e_rsp;
        logic        e_rej;
        bit          e_chkd;
        logic [10:0] e_addr;
        logic [19:0] e_mask;
    } vec_t;
    vec_t vq[$];

    localparam logic [43:0] FIX_ADDRS = {11'h123, 11'h005, 11'h2AA, 11'h011};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic ls, logic ld, logic we, logic [12:0] wa, logic [3:0] rv,
                                logic [1:0] em, logic ewen, logic [3:0] erdy, logic [3:0] ersp,
                                logic erej);
        vec_t v;
        v.ls = ls; v.ld = ld; v.we = we; v.wa = wa; v.rv = rv;
        v.e_mode = em; v.e_wen = ewen; v.e_rdy = erdy; v.e_rsp = ersp; v.e_rej = erej;
        v.e_chkd = 1'b0; v.e_addr = 11'h0; v.e_mask = 20'h0;
        return v;
    endfunction

    task automatic drive(input logic ls, input logic ld, input logic we, input logic [12:0] wa,
                         input logic [30:0] wd, input logic [3:0] rv, input logic [43:0] ra);
        bus.load_start_i  = ls;
        bus.load_done_i   = ld;
        bus.axi_wr_en_i   = we;
        bus.axi_wr_addr_i = wa;
        bus.axi_wr_data_i = wd;
        bus.req_valid_i   = rv;
        bus.req_addr_i    = ra;
    endtask

    function automatic int pick(int ptr, logic [3:0] rv);
        for (int i = 1; i <= 4; i++) begin
            if (rv[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 3; m_pv = 1'b0; m_pi = 0; m_pa = 11'h0; m_rej = 1'b0;
    endtask

    // Checks current-cycle outputs against the model, then advances the model across the edge
    task automatic model_cycle();
        int          g;
        int          nxt;
        logic [3:0]  e_rdy;
        logic [3:0]  e_rsp;
        logic [10:0] e_rd;
        logic [1:0]  e_mode;
        logic [43:0] ra;
        ra = bus.req_addr_i;
        g = (m_mode == 2 && !bus.load_start_i) ? pick(m_ptr, bus.req_valid_i) : -1;
        e_rdy = 4'b0000;
        e_rd = 11'h0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_rd = ra[g*11 +: 11];
        end
        e_rsp = 4'b0000;
        if (m_pv) e_rsp[m_pi] = 1'b1;
        e_mode = 2'(m_mode);
        chk("mode", bus.mode_o, e_mode);
        chk("wr_en", bus.att_wr_en_o, bus.axi_wr_en_i && (m_mode == 1));
        chk("wr_addr", bus.att_wr_addr_o, bus.axi_wr_addr_i);
        chk("wr_data", bus.att_wr_data_o, bus.axi_wr_data_i);
        chk("ready", bus.req_ready_o, e_rdy);
        chk("rd_addr", bus.att_rd_addr_o, e_rd);
        chk("rsp_valid", bus.rsp_valid_o, e_rsp);
        if (m_pv) begin
            chk("rsp_addr", bus.rsp_addr_o, mem_a[m_pa]);
            chk("rsp_mask", bus.rsp_mask_o, mem_m[m_pa]);
        end
        chk("reject", bus.wr_reject_o, m_rej);
        case (m_mode)
            0:       nxt = bus.load_start_i ? 1 : 0;
            1:       nxt = bus.load_done_i ? 2 : 1;
            2:       nxt = bus.load_start_i ? 3 : 2;
            default: nxt = 1;
        endcase
        if (bus.axi_wr_en_i && m_mode != 1) m_rej = 1'b1;
        else if (nxt == 1 && m_mode != 1) m_rej = 1'b0;
        m_mode = nxt;
        m_pv = (g >= 0);
        m_pi = (g >= 0) ? g : 0;
        m_pa = e_rd;
        if (g >= 0) m_ptr = g;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = 11'($urandom());
            mem_m[i] = 20'($urandom());
        end
        mem_a[5] = 11'h03A;
        mem_m[5] = 20'h00011;

        // ls, ld, we, wa, rv | mode, wr_en, ready, rsp_valid, reject
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 13'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 13'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 13'h5, 4'h0, 2'd1, 1'b1, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 13'h5, 4'h0, 2'd1, 1'b1, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 13'h0, 4'h0, 2'd1, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 13'h5, 4'hF, 2'd1, 1'b1, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 13'h7, 4'h0, 2'd2, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h1, 4'h0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h2, 4'h1, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h4, 4'h2, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h8, 4'h4, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h1, 4'h8, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h2, 4'h1, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h4, 4'h2, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'hF, 2'd2, 1'b0, 4'h8, 4'h4, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h0, 2'd2, 1'b0, 4'h0, 4'h8, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h4, 2'd2, 1'b0, 4'h4, 4'h0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h0, 2'd2, 1'b0, 4'h0, 4'h4, 1'b1));
        vq[$].e_chkd = 1'b1;
        vq[$].e_addr = 11'h03A;
        vq[$].e_mask = 20'h00011;
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h2, 2'd2, 1'b0, 4'h2, 4'h0, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 13'h0, 4'h2, 2'd2, 1'b0, 4'h0, 4'h2, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h2, 2'd3, 1'b0, 4'h0, 4'h0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h2, 2'd1, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 13'h0, 4'h2, 2'd1, 1'b0, 4'h0, 4'h0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 4'h2, 2'd2, 1'b0, 4'h2, 4'h0, 1'b0));

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 13'h0, 31'h0, 4'h0, FIX_ADDRS);
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", bus.rsp_valid_o, 4'h0);
        chk("reset_mode", bus.mode_o, 2'd0);
        chk("reset_reject", bus.wr_reject_o, 1'b0);
        rst_n = 1'b1;
        model_reset();

        for (int r = 0; r < vq.size(); r++) begin
            drive(vq[r].ls, vq[r].ld, vq[r].we, vq[r].wa, 31'h1, vq[r].rv, FIX_ADDRS);
            #2;
            chk($sformatf("tbl%0d_mode", r), bus.mode_o, vq[r].e_mode);
            chk($sformatf("tbl%0d_wr_en", r), bus.att_wr_en_o, vq[r].e_wen);
            chk($sformatf("tbl%0d_ready", r), bus.req_ready_o, vq[r].e_rdy);
            chk($sformatf("tbl%0d_rsp_valid", r), bus.rsp_valid_o, vq[r].e_rsp);
            chk($sformatf("tbl%0d_reject", r), bus.wr_reject_o, vq[r].e_rej);
            if (vq[r].e_chkd) begin
                chk($sformatf("tbl%0d_rsp_addr", r), bus.rsp_addr_o, vq[r].e_addr);
                chk($sformatf("tbl%0d_rsp_mask", r), bus.rsp_mask_o, vq[r].e_mask);
            end
            model_cycle();
        end

        // Reset one cycle after a grant: the pending response must vanish at once
        drive(1'b0, 1'b0, 1'b0, 13'h0, 31'h0, 4'h2, FIX_ADDRS);
        #2;
        chk("pre_reset_rsp_valid", bus.rsp_valid_o, 4'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", bus.rsp_valid_o, 4'h0);
        chk("mid_reset_mode", bus.mode_o, 2'd0);
        chk("mid_reset_ready", bus.req_ready_o, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 13'h0, 31'h0, 4'h0, FIX_ADDRS);
        #2;
        chk("post_reset_mode", bus.mode_o, 2'd0);
        chk("post_reset_reject", bus.wr_reject_o, 1'b0);
        model_cycle();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic ls, ld, we;
            ls = ($urandom_range(0, 9) == 0);
            ld = ($urandom_range(0, 5) == 0);
            we = ($urandom_range(0, 3) == 0);
            if (m_mode == 3 || (m_mode == 0 && ls)) we = 1'b0;
            drive(ls, ld, we, 13'($urandom()), 31'($urandom()), 4'($urandom()),
                  44'({$urandom(), $urandom()}));
            #2;
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
